// File: rtl/lcm_pkg.sv
// lcm_pkg: constants shared by the arithmetic-library sequencers.
//   DefaultWidth - default operand width of lcm_calc.
//   lcm_state_e  - three-state sequencing encoding; the GCD unit uses the same encoding.
package lcm_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } lcm_state_e;

endpackage

// File: rtl/lcm_calc.sv
// lcm_calc: multi-cycle least-common-multiple engine for two unsigned WIDTH-bit operands.
// It walks multiples of each operand upward, always advancing the smaller one,
// until the two multiples meet.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high reset
//   start   - request; only sampled while idle
//   a, b    - operands, captured on the accepting edge
//   lcm_val - 2*WIDTH-bit result, held until the next result is written
//   done    - one-cycle pulse while lcm_val is freshly valid
//   busy    - high while the computation is in progress
module lcm_calc
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] lcm_val,
  output logic               done,
  output logic               busy
);

  lcm_state_e         state_q;
  logic [WIDTH-1:0]   ra_q, rb_q;
  logic [2*WIDTH-1:0] x_q, y_q;

  // One shared adder: the smaller multiple is advanced by its own operand.
  // x and y never exceed lcm(a,b), so the sum cannot overflow 2*WIDTH bits.
  logic               x_lt_y;
  logic [2*WIDTH-1:0] add_base;
  logic [WIDTH-1:0]   add_inc;
  logic [2*WIDTH-1:0] sum;

  always_comb begin
    x_lt_y   = (x_q < y_q);
    add_base = x_lt_y ? x_q : y_q;
    add_inc  = x_lt_y ? ra_q : rb_q;
    sum      = add_base + {{WIDTH{1'b0}}, add_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      lcm_val <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            x_q     <= {{WIDTH{1'b0}}, a};
            y_q     <= {{WIDTH{1'b0}}, b};
            state_q <= StCalc;
            busy    <= 1'b1;
          end
        end
        StCalc: begin
          if (ra_q == '0 || rb_q == '0) begin
            // A zero operand has no positive common multiple; report 0.
            lcm_val <= '0;
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (x_q == y_q) begin
            lcm_val <= x_q;
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (x_lt_y) begin
            x_q <= sum;
          end else begin
            y_q <= sum;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_calc.sv
// tb_lcm_calc: randomized and directed checks of lcm_calc against a transaction-level
// model (lcm via Euclid, latency via lcm/a + lcm/b - 1), compared every cycle.
module tb_lcm_calc;

  localparam int unsigned W = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] lcm_val;
  logic           done;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit chk_en      = 1'b0;

  lcm_calc #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .lcm_val(lcm_val),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int unsigned ref_lcm(input int unsigned p, input int unsigned q);
    int unsigned g, h, t;
    if (p == 0 || q == 0) return 0;
    g = p;
    h = q;
    while (h != 0) begin
      t = g % h;
      g = h;
      h = t;
    end
    return (p / g) * q;
  endfunction

  // Cycles spent computing: one per addition plus the final compare.
  function automatic int unsigned ref_k(input int unsigned p, input int unsigned q);
    int unsigned l;
    if (p == 0 || q == 0) return 1;
    l = ref_lcm(p, q);
    return l / p + l / q - 1;
  endfunction

  int unsigned    m_cnt = 0;
  int unsigned    m_pend = 0;
  logic           exp_busy, exp_done;
  logic [2*W-1:0] exp_val;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt    <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_val  <= '0;
    end else if (m_cnt > 0) begin
      m_cnt    <= m_cnt - 1;
      exp_busy <= (m_cnt > 1);
      if (m_cnt == 1) begin
        exp_done <= 1'b1;
        exp_val  <= (2*W)'(m_pend);
      end
    end else if (exp_done) begin
      exp_done <= 1'b0;
    end else if (start) begin
      m_pend   <= ref_lcm(a, b);
      m_cnt    <= ref_k(a, b);
      exp_busy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (busy !== exp_busy || done !== exp_done || lcm_val !== exp_val) begin
        miscompares++;
        $display("FAIL cycle %0d: busy/done/lcm_val got %b/%b/%0d required %b/%b/%0d",
                 cyc, busy, done, lcm_val, exp_busy, exp_done, exp_val);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int unsigned got, input int unsigned want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Issue one pair from an idle cycle; check result and latency against literals.
  task automatic run(input int unsigned pa, input int unsigned pb,
                     input int unsigned want_val, input int unsigned want_k);
    int n;
    @(negedge clk);
    start = 1'b1;
    a     = W'(pa);
    b     = W'(pb);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL timeout lcm(%0d,%0d): no done within 64 cycles", pa, pb);
    end else begin
      check($sformatf("lcm(%0d,%0d) value", pa, pb), lcm_val, want_val);
      check($sformatf("lcm(%0d,%0d) latency", pa, pb), n, want_k);
    end
    @(negedge clk);
    check("idle after done busy", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cyc[$];
    int ndone;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset lcm_val", lcm_val, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    reset = 1'b0;

    run(4, 6, 12, 4);
    run(5, 5, 5, 1);
    run(0, 9, 0, 1);
    run(1, 1, 1, 1);
    run(15, 14, 210, 28);

    // start held high; a/b scrambled while busy must not matter.
    @(negedge clk);
    start = 1'b1;
    a = 4'd3;
    b = 4'd4;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(cyc);
        check("held-start value", lcm_val, 12);
      end
      if (busy) begin
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        a = 4'd3;
        b = 4'd4;
      end
    end
    start = 1'b0;
    ndone = done_cyc.size();
    check("held-start done count >= 3", (ndone >= 3) ? 1 : 0, 1);
    for (int i = 1; i < ndone; i++) check("held-start interval", done_cyc[i] - done_cyc[i-1], 8);
    repeat (12) @(negedge clk);

    // Reset during the third CALC cycle aborts silently.
    start = 1'b1;
    a = 4'd15;
    b = 4'd14;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort lcm_val", lcm_val, 0);
    check("abort done", done, 0);
    check("abort busy", busy, 0);
    reset = 1'b0;
    run(2, 3, 6, 4);

    // Reset and start on the same edge: reset wins, next start accepted.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    a = 4'd3;
    b = 4'd5;
    @(negedge clk);
    check("reset+start busy", busy, 0);
    check("reset+start lcm_val", lcm_val, 0);
    reset = 1'b0;
    @(negedge clk);
    check("start after reset busy", busy, 1);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("lcm(3,5) held", lcm_val, 15);

    // Randomized traffic, including zero operands and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      a     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      b     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcm_calc.md
# lcm_calc

Multi-cycle least-common-multiple engine for two unsigned WIDTH-bit operands. It is the additive counterpart of the subtraction-based GCD unit in the same arithmetic library. It steps multiples of each operand upward until they meet, rather than subtracting down to the divisor. It sits beside the GCD unit and uses a start/done handshake, so a controller can issue one operand pair at a time.

## Interface
- WIDTH, 4: operand width in bits; result is 2*WIDTH bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clock clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- lcm_val  output  2*WIDTH  result; registered, held until the next result is written.
- done  output  1  registered, one-cycle pulse when lcm_val is valid.
- busy  output  1  high while a computation is in progress (CALC state).

## Operation
- Internal registers:
  - ra, rb: latched operands, WIDTH bits.
  - x, y: running multiples, 2*WIDTH bits.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1: ra<=a, rb<=b, x<=a, y<=b, then go to CALC.
  - Otherwise stay in IDLE.
- CALC, evaluated each edge in priority order:
  1. ra==0 or rb==0: lcm_val<=0, then go to DONE.
  2. x==y: lcm_val<=x, then go to DONE.
  3. x<y: x<=x+ra (ra zero-extended), stay in CALC.
  4. Otherwise (x>y): y<=y+rb, stay in CALC.
- DONE: unconditionally go to IDLE. A start seen in DONE is ignored.
- Width rule:
  - Invariant x,y ≤ lcm(a,b) ≤ (2^WIDTH−1)^2 < 2^(2*WIDTH), so additions never overflow.
  - No saturation or wrap handling is required.
- start in CALC or DONE is ignored. It is not queued, and the a/b inputs are ignored in those states.
- Outputs:
  - busy = (state==CALC).
  - done = 1 exactly while state==DONE, and registered.
- Reset:
  - state<=IDLE; lcm_val, x, y, ra, rb <= 0; done=0, busy=0.
  - Reset mid-computation aborts with no done pulse.
  - Reset dominates start on the same edge.

## Timing
- Accepting edge T: start=1 in IDLE.
- CALC occupies K cycles, where K = (additions + 1) and additions = lcm/a + lcm/b − 2.
  - If either operand is 0, K = 1.
- lcm_val is updated and done=1 in the cycle after edge T+K. busy is high for cycles T+1 … T+K.
- Worst case for WIDTH=4: a=15, b=14 gives 27 additions, so K=28.
- Back-to-back operation: the earliest next accept is the edge after the DONE cycle (T+K+2). The minimum issue interval is K+2 cycles.
- lcm_val is stable from the DONE cycle until the next CALC exit.

## Structure
- Shared package lcm_pkg holds:
  - State encoding constants: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - The default WIDTH constant.
  - The GCD unit uses the same state encoding.
- No sub-module. The step is a single compare and a single 2*WIDTH adder, muxed between x/ra and y/rb. One registered FSM holds all state.

## Test plan
- a=4, b=6, start pulse: busy for 4 cycles, then done=1 for one cycle with lcm_val=12, then busy=0 and back in IDLE.
- a=5, b=5: K=1, lcm_val=5. Separately, a=0, b=9 gives lcm_val=0 with K=1; a=1, b=1 gives lcm_val=1.
- a=15, b=14: lcm_val=210 (8'hD2), done exactly 28 cycles after the start edge plus one. No overflow is seen on x or y.
- start held high continuously with a=3, b=4: results 12, 12, … with one done per 8-cycle interval (K=6, plus DONE, plus accept). Changing a/b during CALC does not alter the result.
- Reset asserted on the 3rd CALC cycle of a=15, b=14: the next cycle has IDLE with lcm_val=0, done=0, busy=0, and no done pulse. A new start with a=2, b=3 then returns 6.
- Reset and start high on the same edge: remains IDLE with outputs 0. start on the following edge is accepted normally.
